uart_receiver: RTL and testbench

//  Serial-to-parallel UART receiver; the receive-side companion of the UART transmitter.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 44 ++++
 rtl/uart_receiver.sv | 178 +++++++++++++++++
 tb/tb_uart_receiver.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//  Definitions shared by the UART receiver and transmitter:
//  - uart_state_t : receive/transmit FSM state encoding
//  - uart_period_clk() : clocks per bit derived from clock and baud rate
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } uart_state_t;

    // Integer clocks per bit; callers must keep the result >= 4 so that the
    // half-bit start qualification still has room after synchronizer latency.
    function automatic int uart_period_clk(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
//  Free-running bit-period counter with a loadable target. Emits a one-cycle
//  tick when the count reaches target-1, then wraps to zero.
// Ports
//  i_clk      in   1        system clock
//  i_reset    in   1        asynchronous active-high reset
//  i_clear    in   1        hold counter at zero (no tick while asserted)
//  iv_target  in   p_TGT_W  period in clocks
//  o_tick     out  1        high in the last clock of each period
// ---------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int p_CNT_W = 4,
    parameter int p_TGT_W = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic [p_TGT_W-1:0] iv_target,
    output logic               o_tick
);

    localparam logic [p_CNT_W-1:0] lp_CNT_ONE = p_CNT_W'(1);
    localparam logic [p_TGT_W-1:0] lp_TGT_ONE = p_TGT_W'(1);

    logic [p_CNT_W-1:0] r_cnt;
    logic [p_TGT_W-1:0] w_cnt_ext;

    // Target may need one more bit than the counter when the period is a
    // power of two; compare in the wider domain.
    assign w_cnt_ext = p_TGT_W'(r_cnt);
    assign o_tick    = !i_clear && (w_cnt_ext == (iv_target - lp_TGT_ONE));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_clear || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + lp_CNT_ONE;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//  Serial-to-parallel UART receiver. Synchronizes the raw line, qualifies
//  the start bit at half a bit period, samples data/parity/stop at mid-bit
//  and presents each frame as a one-cycle pulse with parity/framing status.
// Ports
//  i_clk         in   1            system clock
//  i_reset       in   1            asynchronous active-high reset
//  i_input       in   1            raw serial line (idle high, async)
//  ov_data       out  p_DATA_BITS  last received word, LSB first on line
//  o_data_valid  out  1            one-cycle pulse: data/flags updated
//  o_parity_err  out  1            parity mismatch in last frame
//  o_frame_err   out  1            a stop bit sampled low in last frame
//  o_busy        out  1            receiver not idle
// ---------------------------------------------------------------------------
module uart_receiver
    import uart_pkg::*;
#(
    parameter int p_CLK_FREQUENCY = 12000000,
    parameter int p_BAUD_RATE     = 115200,
    parameter int p_DATA_BITS     = 8,
    parameter int p_2_STOP_BITS   = 0,
    parameter int p_PARITY        = 0,
    parameter int p_PARITY_ODD    = 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_input,
    output logic [p_DATA_BITS-1:0] ov_data,
    output logic                   o_data_valid,
    output logic                   o_parity_err,
    output logic                   o_frame_err,
    output logic                   o_busy
);

    localparam int lp_PERIOD_CLK = uart_period_clk(p_CLK_FREQUENCY, p_BAUD_RATE);
    localparam int lp_CNT_W      = $clog2(lp_PERIOD_CLK);
    localparam int lp_TGT_W      = $clog2(lp_PERIOD_CLK + 1);
    localparam int lp_BIT_W      = $clog2(p_DATA_BITS + 1);

    localparam logic [lp_TGT_W-1:0] lp_TGT_FULL = lp_TGT_W'(lp_PERIOD_CLK);
    localparam logic [lp_TGT_W-1:0] lp_TGT_HALF = lp_TGT_W'(lp_PERIOD_CLK / 2);
    localparam logic [lp_BIT_W-1:0] lp_LAST_BIT = lp_BIT_W'(p_DATA_BITS - 1);
    localparam logic [lp_BIT_W-1:0] lp_BIT_ONE  = lp_BIT_W'(1);
    localparam logic lp_HAS_PARITY = (p_PARITY != 0);
    localparam logic lp_TWO_STOP   = (p_2_STOP_BITS != 0);
    localparam logic lp_ODD        = (p_PARITY_ODD != 0);

    logic [1:0]             r_sync;
    logic                   w_rxs;
    uart_state_t            r_state;
    logic [p_DATA_BITS-1:0] r_shift;
    logic [lp_BIT_W-1:0]    r_bit_cnt;
    logic                   r_stop_cnt;
    logic                   r_par_err;
    logic                   r_frm_err;
    logic                   r_done;
    logic                   w_tick;
    logic                   w_clear;
    logic [lp_TGT_W-1:0]    w_target;

    // Two-flop synchronizer, preset to the idle (high) line level.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_input};
        end
    end

    assign w_rxs = r_sync[1];

    // The counter is held at zero while waiting for a line edge, so START
    // always begins at zero; every other state is entered on a tick, where
    // the counter wraps to zero by itself.
    assign w_clear  = (r_state == ST_IDLE) || (r_state == ST_WAIT_HIGH);
    assign w_target = (r_state == ST_START) ? lp_TGT_HALF : lp_TGT_FULL;
    assign o_busy   = (r_state != ST_IDLE);

    uart_baud_tick #(
        .p_CNT_W (lp_CNT_W),
        .p_TGT_W (lp_TGT_W)
    ) u_baud (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (w_clear),
        .iv_target (w_target),
        .o_tick    (w_tick)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_stop_cnt   <= 1'b0;
            r_par_err    <= 1'b0;
            r_frm_err    <= 1'b0;
            r_done       <= 1'b0;
            ov_data      <= '0;
            o_data_valid <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            o_data_valid <= 1'b0;

            // Publish the completed frame one cycle after the last stop
            // sample, independent of the state the FSM has moved on to.
            if (r_done) begin
                o_data_valid <= 1'b1;
                ov_data      <= r_shift;
                o_parity_err <= r_par_err;
                o_frame_err  <= r_frm_err;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!w_rxs) begin
                        r_state    <= ST_START;
                        r_bit_cnt  <= '0;
                        r_stop_cnt <= 1'b0;
                        r_par_err  <= 1'b0;
                        r_frm_err  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_state <= w_rxs ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_shift <= {w_rxs, r_shift[p_DATA_BITS-1:1]};
                        if (r_bit_cnt == lp_LAST_BIT) begin
                            r_bit_cnt <= '0;
                            r_state   <= lp_HAS_PARITY ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + lp_BIT_ONE;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        // Data ones plus parity bit must be odd (odd mode)
                        // or even (even mode).
                        r_par_err <= (^r_shift) ^ w_rxs ^ lp_ODD;
                        r_state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (!w_rxs) begin
                            r_frm_err <= 1'b1;
                        end
                        if (r_stop_cnt == lp_TWO_STOP) begin
                            r_done  <= 1'b1;
                            // A low final stop means break/stuck line: wait
                            // for high so it cannot re-trigger a start.
                            r_state <= w_rxs ? ST_IDLE : ST_WAIT_HIGH;
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    if (w_rxs) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//  Two receivers on separate lines: dut_a 8N1, dut_b 8 data/odd parity/2 stop.
//  Frames are described at bit level; the expected word and flags come from
//  the frame contents (data, parity ones count, stop levels) and are queued
//  for a pulse monitor per receiver.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int CLK_HZ = 12000000;
    localparam int BAUD   = 1000000;
    localparam int P      = CLK_HZ / BAUD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       line_a, line_b;
    logic [7:0] data_a, data_b;
    logic       vld_a, perr_a, ferr_a, busy_a;
    logic       vld_b, perr_b, ferr_b, busy_b;

    uart_receiver #(
        .p_CLK_FREQUENCY (CLK_HZ), .p_BAUD_RATE (BAUD), .p_DATA_BITS (8),
        .p_2_STOP_BITS (0), .p_PARITY (0), .p_PARITY_ODD (1)
    ) dut_a (
        .i_clk (clk), .i_reset (rst), .i_input (line_a), .ov_data (data_a),
        .o_data_valid (vld_a), .o_parity_err (perr_a), .o_frame_err (ferr_a),
        .o_busy (busy_a)
    );

    uart_receiver #(
        .p_CLK_FREQUENCY (CLK_HZ), .p_BAUD_RATE (BAUD), .p_DATA_BITS (8),
        .p_2_STOP_BITS (1), .p_PARITY (1), .p_PARITY_ODD (1)
    ) dut_b (
        .i_clk (clk), .i_reset (rst), .i_input (line_b), .ov_data (data_b),
        .o_data_valid (vld_b), .o_parity_err (perr_b), .o_frame_err (ferr_b),
        .o_busy (busy_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   pulses_a = 0, pulses_b = 0;
    int   pushed_a = 0, pushed_b = 0;

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (vld_a === 1'b1) begin
            pulses_a++;
            if (qa.size() == 0) begin
                chk("a_unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e = qa.pop_front();
                chk("a_data", 32'(data_a), 32'(e.d));
                chk("a_parity_err", 32'(perr_a), 32'(e.pe));
                chk("a_frame_err", 32'(ferr_a), 32'(e.fe));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (vld_b === 1'b1) begin
            pulses_b++;
            if (qb.size() == 0) begin
                chk("b_unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e = qb.pop_front();
                chk("b_data", 32'(data_b), 32'(e.d));
                chk("b_parity_err", 32'(perr_b), 32'(e.pe));
                chk("b_frame_err", 32'(ferr_b), 32'(e.fe));
            end
        end
    end

    // Called at a falling edge; drives a level for n clocks.
    task automatic hold(input bit sel, input logic lvl, input int n);
        if (sel) line_b = lvl;
        else     line_a = lvl;
        repeat (n) @(negedge clk);
    endtask

    // sel=0: 8N1 on line_a; sel=1: 8O2 on line_b. flip inverts the correct
    // parity bit; s1/s2 are stop levels (s2 ignored for line_a).
    task automatic send_frame(input bit sel, input logic [7:0] d, input bit flip,
                              input bit s1, input bit s2, input int gap);
        exp_t e;
        logic par;
        par  = (($countones(d) % 2) == 0) ? 1'b1 : 1'b0;
        par  = par ^ flip;
        e.d  = d;
        e.pe = sel ? ((($countones(d) + int'(par)) % 2) == 0) : 1'b0;
        e.fe = !s1 || (sel && !s2);
        if (sel) begin qb.push_back(e); pushed_b++; end
        else     begin qa.push_back(e); pushed_a++; end
        hold(sel, 1'b0, P);
        for (int i = 0; i < 8; i++) hold(sel, d[i], P);
        if (sel) hold(sel, par, P);
        hold(sel, s1, P);
        if (sel) hold(sel, s2, P);
        if (gap > 0) hold(sel, 1'b1, gap * P);
    endtask

    int          bc, p0, gap;
    bit          sel, flip, s1, s2, last;
    logic [7:0]  rd;

    initial begin
        rst    = 1'b1;
        line_a = 1'b1;
        line_b = 1'b1;
        @(negedge clk);
        chk("rst_a_data",  32'(data_a), 32'd0);
        chk("rst_a_valid", 32'(vld_a),  32'd0);
        chk("rst_a_perr",  32'(perr_a), 32'd0);
        chk("rst_a_ferr",  32'(ferr_a), 32'd0);
        chk("rst_a_busy",  32'(busy_a), 32'd0);
        chk("rst_b_data",  32'(data_b), 32'd0);
        chk("rst_b_valid", 32'(vld_b),  32'd0);
        chk("rst_b_busy",  32'(busy_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        hold(1'b0, 1'b1, 2 * P);

        // 8N1 0xA5: one clean pulse, idle afterwards
        send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1);
        chk("t1_pulse_count", 32'(pulses_a), 32'd1);
        chk("t1_busy_after",  32'(busy_a),   32'd0);

        // odd parity, 0x01 with correct and wrong parity bit
        send_frame(1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1);
        send_frame(1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 1);
        chk("t2_pulse_count", 32'(pulses_b), 32'd2);

        // 4-clock low glitch on an idle line
        bc = 0;
        p0 = pulses_a;
        line_a = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i == 4) line_a = 1'b1;
            @(negedge clk);
            if (busy_a) bc++;
        end
        chk("t3_busy_seen",  32'(bc > 0),   32'd1);
        chk("t3_busy_short", 32'(bc <= 10), 32'd1);
        chk("t3_no_pulse",   32'(pulses_a), 32'(p0));
        chk("t3_idle",       32'(busy_a),   32'd0);

        // break: line low for 20 bit times
        p0 = pulses_a;
        qa.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1});
        pushed_a++;
        hold(1'b0, 1'b0, 20 * P);
        chk("t4_one_pulse", 32'(pulses_a - p0), 32'd1);
        hold(1'b0, 1'b1, 2 * P);
        chk("t4_no_retrigger", 32'(pulses_a - p0), 32'd1);
        chk("t4_idle", 32'(busy_a), 32'd0);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 1);

        // reset during data bit 4 of 0xFF
        p0 = pulses_a;
        hold(1'b0, 1'b0, P);
        for (int i = 0; i < 4; i++) hold(1'b0, 1'b1, P);
        hold(1'b0, 1'b1, P / 2);
        chk("t5_busy_before", 32'(busy_a), 32'd1);
        chk("t5_data_before", 32'(data_a), 32'h3C);
        rst = 1'b1;
        #1;
        chk("t5_rst_data",  32'(data_a), 32'd0);
        chk("t5_rst_valid", 32'(vld_a),  32'd0);
        chk("t5_rst_busy",  32'(busy_a), 32'd0);
        chk("t5_rst_ferr",  32'(ferr_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        hold(1'b0, 1'b1, P / 2 + 3 * P + P + P);
        chk("t5_no_pulse", 32'(pulses_a), 32'(p0));
        send_frame(1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, 1);

        // 2 stop bits, zero-gap back-to-back frames
        p0 = pulses_b;
        send_frame(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 0);
        send_frame(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 0);
        send_frame(1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 1);
        chk("t6_three_pulses", 32'(pulses_b - p0), 32'd3);

        // randomized frames on both receivers
        for (int k = 0; k < 30; k++) begin
            sel  = 1'($urandom_range(0, 1));
            rd   = 8'($urandom);
            flip = sel && ($urandom_range(0, 3) == 0);
            s1   = ($urandom_range(0, 4) != 0);
            s2   = ($urandom_range(0, 4) != 0);
            gap  = $urandom_range(0, 2);
            last = sel ? s2 : s1;
            if (!last && gap == 0) gap = 1;
            send_frame(sel, rd, flip, s1, s2, gap);
        end

        hold(1'b0, 1'b1, 3 * P);
        hold(1'b1, 1'b1, 3 * P);
        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);
        chk("a_pulse_total",   32'(pulses_a),  32'(pushed_a));
        chk("b_pulse_total",   32'(pulses_b),  32'(pushed_b));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
